// File: rtl/fifo_read_drain.sv
// fifo_read_drain: pops an rclk-domain FIFO into a 2-entry in-order buffer feeding a valid/ready sink.
// Defining FIFO_RD_CNT_EN adds a wrapping count of words popped on rd_count.
`ifndef DATA
`define DATA 8
`endif

module fifo_read_drain #(
    parameter int DATA_W = `DATA,
    parameter int CNT_W  = 16
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              rempty,
    input  logic [DATA_W-1:0] rdata,
    output logic              rinc,
    input  logic              drain_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [1:0]        buf_lvl,
    output logic [CNT_W-1:0]  rd_count
);

    logic [1:0]        lvl_q, lvl_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic              pop;

    // Pop permission looks only at local occupancy, so m_ready never reaches rinc.
    assign rinc = !rrst && drain_en && !rempty && (lvl_q != 2'd2);
    assign pop  = valid_q && m_ready;

    always_comb begin
        lvl_d  = lvl_q;
        head_d = head_q;
        tail_d = tail_q;
        case (lvl_q)
            2'd0: begin
                if (rinc) begin
                    head_d = rdata;
                    lvl_d  = 2'd1;
                end
            end
            2'd1: begin
                case ({rinc, pop})
                    2'b11: head_d = rdata;
                    2'b10: begin
                        tail_d = rdata;
                        lvl_d  = 2'd2;
                    end
                    2'b01: lvl_d = 2'd0;
                    default: ;
                endcase
            end
            2'd2: begin
                if (pop) begin
                    head_d = tail_q;
                    lvl_d  = 2'd1;
                end
            end
            default: lvl_d = 2'd0;
        endcase
        valid_d = (lvl_d != 2'd0);
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            lvl_q   <= 2'd0;
            valid_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            lvl_q   <= lvl_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign m_valid = valid_q;
    assign m_data  = head_q;
    assign buf_lvl = lvl_q;

`ifdef FIFO_RD_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (rinc) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge rclk) begin
        if (rrst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign rd_count = cnt_q;
`else
    assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_read_drain.sv
// Bench for fifo_read_drain: directed scenarios plus randomized traffic against a queue model.
module tb_fifo_read_drain;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          rclk = 1'b0;
    logic          rrst, rempty, rinc, drain_en, m_valid, m_ready;
    logic [DW-1:0] rdata, m_data;
    logic [1:0]    buf_lvl;
    logic [CW-1:0] rd_count;

    fifo_read_drain #(.DATA_W(DW), .CNT_W(CW)) dut (
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .drain_en(drain_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .buf_lvl(buf_lvl), .rd_count(rd_count)
    );

    always #5 rclk = ~rclk;

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Source FIFO seen by the DUT; gap forces rempty even when words are waiting.
    logic [DW-1:0] src[$];
    logic          gap;

    task automatic apply();
        rempty = gap || (src.size() == 0);
        rdata  = rempty ? DW'($urandom) : src[0];
    endtask

    task automatic step();
        logic r;
        @(negedge rclk);
        r = rinc;
        @(posedge rclk);
        #1;
        if (r && src.size() > 0) void'(src.pop_front());
        apply();
    endtask

    task automatic reset_dut();
        rrst = 1'b1;
        apply();
        step();
        rrst = 1'b0;
        apply();
    endtask

    // Reference model: output buffer is a queue of words, pop count mod 2^CW.
    logic [DW-1:0] mq[$];
    int            mcnt   = 0;
    bit            mdl_on = 0;

    always @(negedge rclk) begin
        logic exp_rinc, exp_v;
        int   exp_cnt;
        if (rrst) begin
            chk("rst_rinc", {63'd0, rinc}, 64'd0);
            mq.delete();
            mcnt   = 0;
            mdl_on = 1;
        end else if (mdl_on) begin
            exp_v    = (mq.size() != 0);
            exp_rinc = drain_en && !rempty && (mq.size() < 2);
`ifdef FIFO_RD_CNT_EN
            exp_cnt = mcnt;
`else
            exp_cnt = 0;
`endif
            chk("rinc", {63'd0, rinc}, {63'd0, exp_rinc});
            chk("m_valid", {63'd0, m_valid}, {63'd0, exp_v});
            chk("buf_lvl", {62'd0, buf_lvl}, 64'(mq.size()));
            if (exp_v) chk("m_data", {56'd0, m_data}, {56'd0, mq[0]});
            chk("rd_count", {60'd0, rd_count}, 64'(exp_cnt));
            if (exp_v && m_ready) void'(mq.pop_front());
            if (exp_rinc) begin
                mq.push_back(rdata);
                mcnt = (mcnt + 1) % (1 << CW);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] got[$];
        int n, first, last, order_err;

        rrst = 1'b1; drain_en = 1'b0; m_ready = 1'b0; gap = 1'b0;
        apply();
        step();
        step();
        rrst = 1'b0;
        apply();
        #1;
        chk("rst_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_lvl", {62'd0, buf_lvl}, 64'd0);
        chk("rst_cnt", {60'd0, rd_count}, 64'd0);
        chk("rst_data", {56'd0, m_data}, 64'd0);

        // Pass-through of a single word with one cycle latency.
        src.push_back(8'hA5);
        drain_en = 1'b1; m_ready = 1'b1;
        apply();
        #1;
        chk("pt_rinc", {63'd0, rinc}, 64'd1);
        step();
        #1;
        chk("pt_valid", {63'd0, m_valid}, 64'd1);
        chk("pt_data", {56'd0, m_data}, 64'hA5);
        step();

        // Backpressure: only two pops fit, head holds at word 0.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) src.push_back(8'(8'h10 + i));
        apply();
        n = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (rinc) n++;
            step();
        end
        chk("bp_pulses", 64'(n), 64'd2);
        #1;
        chk("bp_lvl", {62'd0, buf_lvl}, 64'd2);
        chk("bp_data", {56'd0, m_data}, 64'h10);
        m_ready = 1'b1;
        apply();
        got.delete();
        for (int i = 0; i < 10; i++) begin
            #1;
            if (m_valid) got.push_back(m_data);
            step();
        end
        chk("bp_count", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk("bp_order", {56'd0, got[i]}, 64'(8'h10 + i));

        // Empty FIFO: no pops while rempty is high.
        n = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (rinc) n++;
            step();
        end
        chk("empty_rinc", 64'(n), 64'd0);
        #1;
        chk("empty_valid", {63'd0, m_valid}, 64'd0);
        chk("empty_lvl", {62'd0, buf_lvl}, 64'd0);

        // Reset with a full buffer, then clean restart from the FIFO head.
        m_ready = 1'b0;
        src.push_back(8'h20); src.push_back(8'h21); src.push_back(8'h22);
        apply();
        repeat (4) step();
        #1;
        chk("mid_lvl", {62'd0, buf_lvl}, 64'd2);
        rrst = 1'b1;
        apply();
        #1;
        chk("mid_rinc", {63'd0, rinc}, 64'd0);
        step();
        rrst = 1'b0; m_ready = 1'b1;
        apply();
        #1;
        chk("mid_valid", {63'd0, m_valid}, 64'd0);
        chk("mid_lvl0", {62'd0, buf_lvl}, 64'd0);
        chk("mid_cnt", {60'd0, rd_count}, 64'd0);
        chk("restart_rinc", {63'd0, rinc}, 64'd1);
        step();
        #1;
        chk("restart_data", {56'd0, m_data}, 64'h22);
        repeat (3) step();

        // Counter wrap: 17 pops on a 4-bit counter.
        reset_dut();
        src.delete();
        for (int i = 0; i < 17; i++) src.push_back(8'(8'h40 + i));
        apply();
        repeat (25) step();
        #1;
`ifdef FIFO_RD_CNT_EN
        chk("cnt_wrap", {60'd0, rd_count}, 64'd1);
`else
        chk("cnt_off", {60'd0, rd_count}, 64'd0);
`endif

        // Streaming: 100 back-to-back words.
        reset_dut();
        src.delete();
        for (int i = 0; i < 100; i++) src.push_back(8'(i));
        apply();
        got.delete();
        first = -1; last = -1;
        for (int c = 0; c < 150; c++) begin
            #1;
            if (m_valid && m_ready) begin
                if (first < 0) first = c;
                last = c;
                got.push_back(m_data);
            end
            step();
        end
        chk("stream_count", 64'(got.size()), 64'd100);
        chk("stream_span", 64'(last - first), 64'd99);
        order_err = 0;
        for (int i = 0; i < got.size(); i++)
            if (got[i] != 8'(i)) order_err++;
        chk("stream_order", 64'(order_err), 64'd0);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            drain_en = ($urandom % 10) < 8;
            m_ready  = ($urandom % 10) < 6;
            gap      = ($urandom % 10) < 2;
            rrst     = ($urandom % 100) == 0;
            while (src.size() < 4) src.push_back(DW'($urandom));
            apply();
            step();
        end

        rrst = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_read_drain.md
FIFO_READ_DRAIN -- requirements
Module: fifo_read_drain

Interface
REQ-001 SHALL have parameter DATA_W, default `DATA (from defines.svh), giving the read data width.
REQ-002 SHALL have parameter CNT_W, default 16, giving the read-counter width.
REQ-003 SHALL have port rclk, input, 1, the read-domain clock; the single clock of the block.
REQ-004 SHALL have port rrst, input, 1, the reset; synchronous, active-high.
REQ-005 SHALL have port rempty, input, 1, the FIFO empty flag in the rclk domain.
REQ-006 SHALL have port rdata, input, DATA_W, the FIFO head word, valid while rempty=0.
REQ-007 SHALL have port rinc, output, 1, the FIFO pop strobe.
REQ-008 SHALL have port drain_en, input, 1, which permits popping from the FIFO.
REQ-009 SHALL have port m_data, output, DATA_W, the downstream data.
REQ-010 SHALL have port m_valid, output, 1, the downstream valid.
REQ-011 SHALL have port m_ready, input, 1, the downstream ready.
REQ-012 SHALL have port buf_lvl, output, 2, the output-buffer occupancy (0..2).
REQ-013 SHALL have port rd_count, output, CNT_W, the count of words popped.

Function
REQ-014 SHALL contain a 2-entry in-order output buffer with registered occupancy lvl, equal to buf_lvl.
REQ-015 SHALL drive rinc = !rrst & drain_en & !rempty & (lvl<2), combinationally, with no path from m_ready.
REQ-016 SHALL never assert rinc while rempty=1, which is the read-while-empty rule.
REQ-017 SHALL write rdata into the buffer tail on the rclk edge where rinc=1, capturing the pre-pop head word.
REQ-018 SHALL drive m_valid = (lvl!=0) and m_data = the buffer head entry, both from registers.
REQ-019 SHALL pop the buffer head on an edge where m_valid=1 and m_ready=1.
REQ-020 SHALL have a latency of 1 cycle: with lvl=0 and a word captured at edge N, m_valid=1 with that word after edge N.
REQ-021 SHALL handle a simultaneous push and pop at lvl=1 by keeping lvl=1, with the new word becoming the head; this sustains 1 word per cycle.
REQ-022 SHALL update occupancy as: lvl=2 with pop gives lvl=1; lvl=2 without pop holds, with rinc=0.
REQ-023 SHALL hold m_data and m_valid stable while m_valid=1 and m_ready=0.
REQ-024 SHALL deliver words to m_data in exactly FIFO order, with no loss or duplication.
REQ-025 SHALL stop rinc in the same cycle drain_en falls, and SHALL still deliver already-buffered words.
REQ-026 SHALL treat an rempty rise as taking effect immediately: no rinc in that cycle.

Reset
REQ-027 SHALL, on an rclk edge with rrst=1, set lvl=0, m_valid=0, m_data=0 and rd_count=0, and discard buffer contents.
REQ-028 SHALL hold rinc=0 during any cycle where rrst=1, regardless of the other inputs.
REQ-029 SHALL, after reset mid-transfer, restart cleanly: the first word after reset is whatever the FIFO presents at its head.

Configuration
REQ-030 SHALL use macro FIFO_RD_CNT_EN: when defined, rd_count increments by 1 on every edge with rinc=1 and wraps from 2^CNT_W-1 to 0.
REQ-031 SHALL, when FIFO_RD_CNT_EN is undefined, tie rd_count to 0 and instantiate no counter logic.

Verification
REQ-032 SHALL cover the basic pass-through scenario: rempty=0, rdata=0xA5, drain_en=1, m_ready=1 -> rinc=1 in cycle 0; m_valid=1 and m_data=0xA5 in cycle 1.
REQ-033 SHALL cover backpressure: m_ready=0 with 4 words available -> rinc pulses exactly twice, buf_lvl=2, m_data stays at word 0; then m_ready=1 -> words 0..3 delivered in order.
REQ-034 SHALL cover the empty boundary: rempty=1 with drain_en=1 for 10 cycles -> rinc=0 throughout, m_valid=0, buf_lvl=0.
REQ-035 SHALL cover reset mid-operation: buf_lvl=2, then rrst=1 for 1 cycle -> m_valid=0, buf_lvl=0, rd_count=0, and rinc=0 in the reset cycle.
REQ-036 SHALL cover the counter wrap with FIFO_RD_CNT_EN defined and CNT_W=4: 17 pops -> rd_count=1; with the macro undefined -> rd_count=0.
REQ-037 SHALL cover streaming: 100 sequential words with m_ready=1 and no empty gaps -> 1 word per cycle after the first, in order with no gaps.
